// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//
// Shared definitions for the host-link UART transmit path.
//
// Contents:
//   tx_state_e      - transmitter state (IDLE / START / DATA / STOP)
//   BITS_PER_BYTE   - data bits per 8N1 character
//   BYTES_PER_WORD  - characters per transmitted word
//   FRAME_BITS      - line bits per character (start + data + stop)
//   WORD_BITS       - width of a transmitted word
//   baud_acc_width  - width of the fractional baud accumulator for a clock
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int BITS_PER_BYTE  = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int FRAME_BITS     = 10;
    localparam int WORD_BITS      = BITS_PER_BYTE * BYTES_PER_WORD;

    // One spare bit above $clog2 keeps acc + BAUD_RATE from overflowing,
    // since the accumulator always holds a value below CLK_FREQ.
    function automatic int baud_acc_width(input int clk_freq);
        return $clog2(clk_freq) + 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
//
// Fractional baud-tick generator. Every enabled cycle the accumulator advances
// by BAUD_RATE; when it reaches CLK_FREQ a tick fires and CLK_FREQ is removed.
// Tick m after a clear therefore lands on cycle ceil(m * CLK_FREQ / BAUD_RATE),
// so non-integer clock/baud ratios average out exactly.
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset (clears the accumulator)
//   clear  in   synchronous clear of the accumulator (start of a new word)
//   enable in   advance the accumulator this cycle
//   tick   out  bit boundary this cycle (combinational from acc and enable)
// ---------------------------------------------------------------------------
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 6000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int ACC_W = baud_acc_width(CLK_FREQ);
    localparam int SUM_W = ACC_W + 1;

    localparam logic [SUM_W-1:0] INC  = SUM_W'(BAUD_RATE);
    localparam logic [SUM_W-1:0] WRAP = SUM_W'(CLK_FREQ);

    logic [ACC_W-1:0] acc;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] wrapped;

    always_comb begin
        sum     = {1'b0, acc} + INC;
        wrapped = sum - WRAP;
        tick    = enable && (sum >= WRAP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            if (sum >= WRAP) begin
                acc <= wrapped[ACC_W-1:0];
            end else begin
                acc <= sum[ACC_W-1:0];
            end
        end
    end

    // The accumulator is always a residue below CLK_FREQ.
    acc_in_range : assert property (
        @(posedge clk) disable iff (rst) {1'b0, acc} < WRAP
    );

endmodule

// File: rtl/uart_word_tx.sv
// ---------------------------------------------------------------------------
// uart_word_tx
//
// Sends 32-bit words as four 8N1 characters, least-significant byte first,
// with no idle gap between the characters of one word. The character after
// the last stop bit of a word is the first possible acceptance cycle, so
// back-to-back words see the final stop bit stretched by one clock.
//
// Handshake: a word transfers on the clock edge where valid_i && ready_o.
// The producer holds valid_i and word_i stable until that edge; ready_o is
// high only in IDLE, and a valid_i seen while ready_o is low is ignored.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset; drops any word in flight
//   word_i     in   word to send; word_i[7:0] leaves first
//   valid_i    in   word_i is valid
//   ready_o    out  block can accept a word (registered)
//   tx_o       out  serial line, idle high (registered)
//   busy_o     out  word in flight, i.e. state != IDLE (registered)
//   dbg_state  out  current transmitter state, for observation only
// ---------------------------------------------------------------------------
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 6000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_BITS-1:0] word_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output tx_state_e            dbg_state
);

    // The state machine needs at least four clocks per bit.
    if (longint'(BAUD_RATE) * 4 > longint'(CLK_FREQ)) begin : g_bad_baud
        $error("uart_word_tx: 4*BAUD_RATE must not exceed CLK_FREQ");
    end

    localparam logic [2:0] LAST_BIT  = 3'(BITS_PER_BYTE - 1);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    tx_state_e            state;
    logic [WORD_BITS-1:0] shreg;
    logic [1:0]           bidx;
    logic [2:0]           bit_idx;
    logic                 accept;
    logic                 tick;

    // ready_o is a register that is only ever high in IDLE, so this needs no
    // further state qualification.
    assign accept    = valid_i && ready_o;
    assign dbg_state = state;

    uart_baud_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (state != IDLE),
        .tick   (tick)
    );

    // All outputs are updated on the same edge as the state, so tx_o always
    // shows the level belonging to the state that has just been entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bidx    <= '0;
            bit_idx <= '0;
            tx_o    <= 1'b1;
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_o <= 1'b1;
                    if (accept) begin
                        shreg   <= word_i;
                        bidx    <= '0;
                        bit_idx <= '0;
                        state   <= START;
                        tx_o    <= 1'b0;
                        ready_o <= 1'b0;
                        busy_o  <= 1'b1;
                    end else begin
                        ready_o <= 1'b1;
                        busy_o  <= 1'b0;
                    end
                end

                START: begin
                    if (tick) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx_o    <= shreg[0];
                    end
                end

                DATA: begin
                    if (tick) begin
                        // Shifting on every data tick leaves the next byte in
                        // shreg[7:0] once a character is complete.
                        shreg <= {1'b0, shreg[WORD_BITS-1:1]};
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                            tx_o  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_o    <= shreg[1];
                        end
                    end
                end

                STOP: begin
                    if (tick) begin
                        if (bidx == LAST_BYTE) begin
                            state   <= IDLE;
                            tx_o    <= 1'b1;
                            ready_o <= 1'b1;
                            busy_o  <= 1'b0;
                        end else begin
                            bidx  <= bidx + 2'd1;
                            state <= START;
                            tx_o  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    tx_o    <= 1'b1;
                    ready_o <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    busy_matches_state : assert property (
        @(posedge clk) disable iff (rst) busy_o == (state != IDLE)
    );

    ready_only_in_idle : assert property (
        @(posedge clk) disable iff (rst) ready_o |-> (state == IDLE)
    );

    start_bit_low : assert property (
        @(posedge clk) disable iff (rst) (state == START) |-> !tx_o
    );

    stop_bit_high : assert property (
        @(posedge clk) disable iff (rst) (state == STOP) |-> tx_o
    );

endmodule

// File: tb/tb_uart_word_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_word_tx
//
// Drives two instances of uart_word_tx: one at 100 MHz / 6 Mbaud and one at
// 100 MHz / 1 Mbaud. Every accepted word and its acceptance cycle go into a
// queue; a monitor per instance replays the expected line waveform from the
// bit-boundary rule ceil(k*F/B) and decodes the data at mid-bit.
//
// Cycle numbering: acceptance edge = cycle 0; the value "at cycle n" is the
// value sampled at edge n, observed here on the falling edge just before it.
// ---------------------------------------------------------------------------
module tb_uart_word_tx;
    import uart_pkg::*;

    localparam longint F     = 100000000;
    localparam longint B     = 6000000;
    localparam longint B_INT = 1000000;

    logic        clk;
    logic        rst;
    logic [31:0] word_i;
    logic        valid_i;
    logic        ready_o;
    logic        tx_o;
    logic        busy_o;
    tx_state_e   dbg_state;

    logic [31:0] word2;
    logic        valid2;
    logic        ready2;
    logic        tx2;
    logic        busy2;
    tx_state_e   state2;

    uart_word_tx #(.CLK_FREQ(100000000), .BAUD_RATE(6000000)) dut (
        .clk       (clk),
        .rst       (rst),
        .word_i    (word_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .tx_o      (tx_o),
        .busy_o    (busy_o),
        .dbg_state (dbg_state)
    );

    uart_word_tx #(.CLK_FREQ(100000000), .BAUD_RATE(1000000)) dut_int (
        .clk       (clk),
        .rst       (rst),
        .word_i    (word2),
        .valid_i   (valid2),
        .ready_o   (ready2),
        .tx_o      (tx2),
        .busy_o    (busy2),
        .dbg_state (state2)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    longint      acc_q[$];
    logic [31:0] exp2_q[$];
    longint      acc2_q[$];

    int  n_checks = 0;
    int  n_fail   = 0;
    int  words_sent  [2];
    int  words_done  [2];
    bit  mon_busy    [2];
    int  n_aborted   = 0;
    bit  abort_req   = 1'b0;
    bit  mon_aborted = 1'b0;
    longint last_acc = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc + 1);
        end
    endtask

    function automatic longint ceil_div(input longint a, input longint b);
        return (a + b - 1) / b;
    endfunction

    // Line level of frame bit k (0..39) for word w: 10 bits per byte,
    // start 0, eight data bits LSB first, stop 1.
    function automatic logic frame_bit(input logic [31:0] w, input int k);
        int p;
        p = k % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return w[(k / 10) * 8 + p - 1];
    endfunction

    // ---------------- monitor ----------------
    task automatic monitor(input int sel, input longint f, input longint b);
        longint      a, fin, off, lo, hi;
        logic [31:0] w, dec;
        int          k, bad;
        logic        line, want, rdy, bsy;
        bit          cut;
        fin = ceil_div(40 * f, b);
        forever begin
            while (((sel == 1) ? acc2_q.size() : acc_q.size()) == 0) @(negedge clk);
            if (sel == 1) begin
                a = acc2_q.pop_front();
                w = exp2_q.pop_front();
            end else begin
                a = acc_q.pop_front();
                w = exp_q.pop_front();
            end
            mon_busy[sel] = 1'b1;
            if (cyc + 1 > a + 1) check($sformatf("dut%0d_monitor_sync", sel), cyc + 1, a + 1);
            while (cyc + 1 < a + 1) @(negedge clk);
            dec = '0;
            bad = 0;
            k   = 0;
            cut = 1'b0;
            for (off = 1; off <= fin + 1; off++) begin
                if (sel == 0 && abort_req) begin
                    cut = 1'b1;
                    break;
                end
                line = (sel == 1) ? tx2 : tx_o;
                rdy  = (sel == 1) ? ready2 : ready_o;
                bsy  = (sel == 1) ? busy2 : busy_o;
                if (off <= fin) begin
                    while (k < 39 && off > ceil_div((k + 1) * f, b)) k++;
                    want = frame_bit(w, k);
                    if (line !== want || rdy !== 1'b0 || bsy !== 1'b1) begin
                        if (bad == 0)
                            $display("  dut%0d word %08h: first line error at cycle offset %0d tx=%b want %b ready=%b busy=%b",
                                     sel, w, off, line, want, rdy, bsy);
                        bad++;
                    end
                    lo = ceil_div(k * f, b) + 1;
                    hi = ceil_div((k + 1) * f, b);
                    if ((k % 10) != 0 && (k % 10) != 9 && off == (lo + hi) / 2)
                        dec[(k / 10) * 8 + (k % 10) - 1] = line;
                    @(negedge clk);
                end else begin
                    check($sformatf("dut%0d_ready_return", sel), rdy, 1'b1);
                    check($sformatf("dut%0d_busy_clear", sel), bsy, 1'b0);
                    check($sformatf("dut%0d_tx_idle", sel), line, 1'b1);
                    check($sformatf("dut%0d_state_idle", sel),
                          (sel == 1) ? state2 : dbg_state, IDLE);
                end
            end
            if (cut) begin
                mon_aborted = 1'b1;
            end else begin
                check($sformatf("dut%0d_frame_bad_cycles", sel), bad, 0);
                check($sformatf("dut%0d_word", sel), dec, w);
                words_done[sel]++;
            end
            mon_busy[sel] = 1'b0;
        end
    endtask

    initial monitor(0, F, B);
    initial monitor(1, F, B_INT);

    // ---------------- driver tasks (called at a falling edge) ----------------
    // Offers w (or a value that keeps changing while the block is busy when
    // scramble is set) and records whatever is on word_i at acceptance.
    task automatic send(input logic [31:0] w, input bit scramble);
        bit     held;
        longint a;
        held    = valid_i;
        word_i  = w;
        valid_i = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (ready_o === 1'b1) begin
                a = cyc + 1;
                if (held && last_acc >= 0)
                    check("b2b_accept_cycle", a, last_acc + ceil_div(40 * F, B) + 1);
                exp_q.push_back(word_i);
                acc_q.push_back(a);
                last_acc = a;
                words_sent[0]++;
                @(negedge clk);
                return;
            end
            if (scramble) word_i = $urandom;
            @(negedge clk);
        end
        check("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        word_i  = $urandom;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 10000; i++) begin
            if (acc_q.size() == 0 && acc2_q.size() == 0 && !mon_busy[0] && !mon_busy[1]) return;
            @(negedge clk);
        end
        check("drain_timeout", 0, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [31:0] w;
        longint      target;
        int          gap;

        rst     = 1'b0;
        valid_i = 1'b0;
        word_i  = '0;
        valid2  = 1'b0;
        word2   = '0;
        #2 rst  = 1'b1;
        #1;
        check("rst_tx", tx_o, 1'b1);
        check("rst_ready", ready_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_state", dbg_state, IDLE);
        check("rst_tx_int", tx2, 1'b1);
        check("rst_ready_int", ready2, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", ready_o, 1'b1);
        check("ready_after_rst_int", ready2, 1'b1);

        // Single word.
        send(32'h04030201, 1'b0);
        idle(0);
        drain();

        // Back-to-back with valid held high.
        send(32'hDEADBEEF, 1'b0);
        send(32'h00FF55AA, 1'b0);
        idle(0);
        drain();

        // word_i changes every cycle while busy, valid stays high.
        send($urandom, 1'b0);
        send($urandom, 1'b1);
        send($urandom, 1'b1);
        idle(0);
        drain();

        // Random words with random gaps.
        for (int i = 0; i < 30; i++) begin
            send($urandom, 1'b0);
            gap = $urandom_range(0, 3);
            if (gap != 0) idle($urandom_range(1, 40));
        end
        idle(0);
        drain();

        // Reset during data bit 3 of byte 2 (frame bit 24), chosen to be a 0.
        w = $urandom & ~32'h0008_0000;
        send(w, 1'b0);
        idle(0);
        target = last_acc + ceil_div(24 * F, B) + 4;
        while (cyc + 1 < target) @(negedge clk);
        #2;
        abort_req = 1'b1;
        rst       = 1'b1;
        n_aborted++;
        #1;
        check("midword_rst_tx", tx_o, 1'b1);
        check("midword_rst_ready", ready_o, 1'b0);
        check("midword_rst_busy", busy_o, 1'b0);
        repeat (2) @(negedge clk);
        check("in_rst_ready", ready_o, 1'b0);
        check("in_rst_state", dbg_state, IDLE);
        rst = 1'b0;
        for (int i = 0; i < 20 && !mon_aborted; i++) @(negedge clk);
        check("monitor_saw_abort", mon_aborted, 1'b1);
        abort_req   = 1'b0;
        mon_aborted = 1'b0;
        @(negedge clk);
        check("ready_after_midword_rst", ready_o, 1'b1);
        send(32'h12345678, 1'b0);
        idle(0);
        drain();

        // Integer ratio: 100 clocks per bit, 4000 clocks per word.
        word2  = 32'h80000001;
        valid2 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (ready2 === 1'b1) begin
                exp2_q.push_back(word2);
                acc2_q.push_back(cyc + 1);
                words_sent[1]++;
                break;
            end
            @(negedge clk);
        end
        check("int_accepted", words_sent[1], 1);
        @(negedge clk);
        valid2 = 1'b0;
        drain();

        check("words_main", words_done[0], words_sent[0] - n_aborted);
        check("words_int", words_done[1], words_sent[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        n_fail++;
        $display("FAIL watchdog: run still active at cycle %0d, limit 100000", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
